lru_cache_ctrl: RTL and testbench

LRU_CACHE_CTRL -- requirements
Module: lru_cache_ctrl

---
 rtl/cache_pkg.sv | 37 +++
 rtl/cache_lru_update.sv | 29 ++
 rtl/lru_cache_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_lru_cache_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the LRU cache controller: FSM state encoding,
// default geometry and helpers that derive address field widths.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  localparam int unsigned DEF_ADDR_W     = 20;
  localparam int unsigned DEF_WAYS       = 4;
  localparam int unsigned DEF_SETS       = 128;
  localparam int unsigned DEF_LINE_BYTES = 64;

  // Floor of 1 keeps degenerate geometries from producing zero-width fields.
  function automatic int unsigned log2c(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned calc_off_w(input int unsigned line_bytes);
    return log2c(line_bytes);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned sets);
    return log2c(sets);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned sets,
                                             input int unsigned line_bytes);
    return addr_w - calc_idx_w(sets) - calc_off_w(line_bytes);
  endfunction

endpackage

// File: rtl/cache_lru_update.sv
// Age update for one set: the accessed way becomes youngest and every valid
// way that was younger than it ages by one, keeping valid ages unique.
module cache_lru_update
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = DEF_WAYS,
  parameter int unsigned AGE_W = log2c(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages_in,
  input  logic [WAYS-1:0]            valid_in,
  input  logic [AGE_W-1:0]           way,
  output logic [WAYS-1:0][AGE_W-1:0] ages_out
);

  logic [AGE_W-1:0] acc_age;

  always_comb begin
    acc_age  = valid_in[way] ? ages_in[way] : AGE_W'(WAYS - 1);
    ages_out = ages_in;
    for (int unsigned j = 0; j < WAYS; j++) begin
      if (AGE_W'(j) == way) begin
        ages_out[j] = '0;
      end else if (valid_in[j] && (ages_in[j] < acc_age)) begin
        ages_out[j] = ages_in[j] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/lru_cache_ctrl.sv
// Set-associative write-back, write-allocate cache controller with true LRU
// replacement, a single outstanding CPU request and a line-wide memory port.
module lru_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned WAYS       = DEF_WAYS,
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    resp_valid,
  output logic [7:0]              resp_rdata,
  output logic                    resp_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic [15:0]             hit_cnt,
  output logic [15:0]             miss_cnt
);

  localparam int unsigned OFF_W  = calc_off_w(LINE_BYTES);
  localparam int unsigned IDX_W  = calc_idx_w(SETS);
  localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, SETS, LINE_BYTES);
  localparam int unsigned AGE_W  = log2c(WAYS);
  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_q;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic [AGE_W-1:0] vict_q;
  logic             first_q;
  logic             gap_q;
  logic [7:0]       rdata_q;
  logic             hit_q;
  logic [15:0]      hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0]            dirty_q [SETS];
  logic [WAYS-1:0][AGE_W-1:0] age_q   [SETS];
  logic [TAG_W-1:0]           tag_mem [SETS][WAYS];
  logic [LINE_W-1:0]          data_mem[SETS][WAYS];

  logic [WAYS-1:0]            set_valid, set_dirty;
  logic [WAYS-1:0][AGE_W-1:0] set_age, new_age;
  logic                       hit, found_inv;
  logic [AGE_W-1:0]           hit_way, vict_way;
  logic [LINE_W-1:0]          hit_line;
  logic [7:0]                 hit_byte;
  logic                       fill_ack;

  always_comb begin
    set_valid = valid_q[idx_q];
    set_dirty = dirty_q[idx_q];
    set_age   = age_q[idx_q];
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vict_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && set_valid[w] && (tag_mem[idx_q][w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found_inv && !set_valid[w]) begin
        found_inv = 1'b1;
        vict_way  = AGE_W'(w);
      end
    end
    if (!found_inv) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (set_age[w] == AGE_MAX) vict_way = AGE_W'(w);
      end
    end
  end

  assign hit_line = data_mem[idx_q][hit_way];
  assign hit_byte = hit_line[{off_q, 3'b000} +: 8];
  // gap_q forces one idle cycle on mem_req between the write-back ack and the fill.
  assign fill_ack = (state_q == FILL) && mem_ack && !gap_q;

  cache_lru_update #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_in  (set_age),
    .valid_in (set_valid),
    .way      (hit_way),
    .ages_out (new_age)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = rst_b;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit)                                       state_d = RESP;
        else if (set_valid[vict_way] && set_dirty[vict_way]) state_d = WB;
        else                                           state_d = FILL;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[idx_q][vict_q], idx_q, {OFF_W{1'b0}}};
        mem_wdata = data_mem[idx_q][vict_q];
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        mem_req  = !gap_q;
        mem_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (fill_ack) state_d = LOOKUP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      vict_q     <= '0;
      first_q    <= 1'b0;
      gap_q      <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == WB) && mem_ack;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q   <= req_addr[OFF_W +: IDX_W];
            off_q   <= req_addr[OFF_W-1:0];
            we_q    <= req_we;
            wdata_q <= req_wdata;
            first_q <= 1'b1;
          end
        end
        LOOKUP: begin
          first_q <= 1'b0;
          if (first_q) begin
            hit_q <= hit;
            if (hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (!hit && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
          end
          if (hit) begin
            age_q[idx_q] <= new_age;
            rdata_q      <= we_q ? wdata_q : hit_byte;
            if (we_q) dirty_q[idx_q][hit_way] <= 1'b1;
          end else begin
            vict_q <= vict_way;
          end
        end
        FILL: begin
          // Oldest age here lets the follow-up hit promote the line through the normal path.
          if (fill_ack) begin
            valid_q[idx_q][vict_q] <= 1'b1;
            dirty_q[idx_q][vict_q] <= 1'b0;
            age_q[idx_q][vict_q]   <= AGE_MAX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b && (state_q == LOOKUP) && hit && we_q)
      data_mem[idx_q][hit_way][{off_q, 3'b000} +: 8] <= wdata_q;
    if (rst_b && fill_ack) begin
      data_mem[idx_q][vict_q] <= mem_rdata;
      tag_mem[idx_q][vict_q]  <= tag_q;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_hit   = hit_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_lru_cache_ctrl.sv
// Self-checking bench for lru_cache_ctrl: directed scenarios plus random
// traffic against a timestamp-LRU model of the cache and a backing memory.
module tb_lru_cache_ctrl;

  localparam int ADDR_W     = 20;
  localparam int WAYS       = 4;
  localparam int SETS       = 128;
  localparam int LINE_BYTES = 64;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         req_valid, req_ready, req_we;
  logic [19:0]  req_addr;
  logic [7:0]   req_wdata;
  logic         resp_valid, resp_hit;
  logic [7:0]   resp_rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [19:0]  mem_addr;
  logic [511:0] mem_wdata, mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  lru_cache_ctrl #(
    .ADDR_W     (ADDR_W),
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  typedef struct {
    logic [6:0]   set;
    logic [6:0]   tag;
    logic         dirty;
    logic [511:0] line;
    int unsigned  stamp;
  } ent_t;

  ent_t         ents[$];
  logic [511:0] mem_m [logic [19:0]];
  int unsigned  passed = 0, total = 0, now_t = 0, m_hits = 0, m_misses = 0;
  logic [19:0]  last_wb_addr;
  logic [511:0] last_wb_data;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] memline(input logic [19:0] a);
    logic [511:0] l;
    if (mem_m.exists(a)) return mem_m[a];
    for (int b = 0; b < 64; b++) l[b*8 +: 8] = 8'(a[19:6] * 3 + b * 29 + 7);
    return l;
  endfunction

  task automatic model_reset();
    ents.delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_req(input logic we, input logic [19:0] addr, input logic [7:0] wd,
                        input int unsigned dly);
    logic [6:0]   idx, tg;
    logic [5:0]   off;
    logic [19:0]  wb_a, fill_a;
    logic [511:0] wb_d, line;
    logic [7:0]   exp_b;
    logic         exp_hit, exp_wb, got, wb_seen, fill_seen;
    int           hi, vi, cnt, n, cyc;
    int unsigned  wcnt;
    ent_t         e;
    idx = addr[12:6]; tg = addr[19:13]; off = addr[5:0];
    hi = -1; vi = -1; cnt = 0;
    for (int i = 0; i < ents.size(); i++) begin
      if (ents[i].set == idx) begin
        cnt++;
        if (ents[i].tag == tg) hi = i;
        if (vi < 0 || ents[i].stamp < ents[vi].stamp) vi = i;
      end
    end
    exp_hit = (hi >= 0);
    exp_wb  = !exp_hit && (cnt == WAYS) && ents[vi].dirty;
    wb_a    = exp_wb ? {ents[vi].tag, idx, 6'b0} : 20'h0;
    wb_d    = exp_wb ? ents[vi].line : '0;
    fill_a  = {tg, idx, 6'b0};

    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; wcnt = 0; got = 0; wb_seen = 0; fill_seen = 0;
    while (cyc < 300) begin
      if (resp_valid === 1'b1) begin got = 1; break; end
      if (mem_req === 1'b1) begin
        check("busy_not_ready", req_ready, 1'b0);
        if (mem_we === 1'b1) begin
          check("wb_addr", mem_addr, wb_a);
          check("wb_data", mem_wdata, wb_d);
          last_wb_addr = mem_addr; last_wb_data = mem_wdata; wb_seen = 1;
          if (wcnt >= dly) begin mem_ack = 1'b1; mem_m[wb_a] = wb_d; wcnt = 0; end
          else wcnt++;
        end else begin
          check("fill_addr", mem_addr, fill_a);
          fill_seen = 1;
          mem_rdata = memline(fill_a);
          if (wcnt >= dly) begin mem_ack = 1'b1; wcnt = 0; end
          else wcnt++;
        end
        req_valid = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0; req_valid = 1'b0;
      cyc++;
    end
    check("resp_seen", got, 1'b1);
    if (exp_hit) check("hit_latency", cyc, 2);
    check("resp_hit", resp_hit, exp_hit);
    check("wb_seen", wb_seen, exp_wb);
    check("fill_seen", fill_seen, !exp_hit);
    line  = exp_hit ? ents[hi].line : memline(fill_a);
    exp_b = we ? wd : line[int'(off)*8 +: 8];
    check("resp_rdata", resp_rdata, exp_b);

    if (exp_hit) begin
      e = ents[hi];
      m_hits++;
    end else begin
      if (cnt == WAYS) ents.delete(vi);
      e.set = idx; e.tag = tg; e.dirty = 1'b0; e.line = memline(fill_a);
      m_misses++;
    end
    e.stamp = now_t;
    if (we) begin e.line[int'(off)*8 +: 8] = wd; e.dirty = 1'b1; end
    if (exp_hit) ents[hi] = e;
    else ents.push_back(e);
    now_t++;
    check("hit_cnt", hit_cnt, 16'(m_hits));
    check("miss_cnt", miss_cnt, 16'(m_misses));
    @(negedge clk);
    check("resp_pulse", resp_valid, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] pre;
    int n;
    rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 20'h0);
    check("rst_hit_cnt", hit_cnt, 16'h0);
    check("rst_miss_cnt", miss_cnt, 16'h0);
    rst_b = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);

    pre = memline(20'h00040);
    pre[56*8 +: 8] = 8'hA5;
    mem_m[20'h00040] = pre;
    do_req(1'b0, 20'h00078, 8'h00, 0);
    check("first_read_byte", resp_rdata, 8'hA5);
    do_req(1'b0, 20'h00078, 8'h00, 0);
    do_req(1'b1, 20'h00079, 8'h3C, 0);
    do_req(1'b0, 20'h00079, 8'h00, 0);
    check("readback_3c", resp_rdata, 8'h3C);

    do_req(1'b1, 20'h02045, 8'h77, 1);
    do_req(1'b0, 20'h04040, 8'h00, 2);
    do_req(1'b0, 20'h06040, 8'h00, 0);
    do_req(1'b0, 20'h00040, 8'h00, 0);
    last_wb_addr = '0; last_wb_data = '0;
    do_req(1'b0, 20'h08040, 8'h00, 5);
    check("evict_tag1_addr", last_wb_addr, 20'h02040);
    check("evict_tag1_byte", last_wb_data[5*8 +: 8], 8'h77);
    do_req(1'b0, 20'h02045, 8'h00, 5);
    check("tag1_refetch", resp_rdata, 8'h77);

    for (int k = 0; k < 250; k++) begin
      do_req(1'($urandom_range(0, 1)),
             {7'($urandom_range(0, 7)), 7'($urandom_range(0, 3)), 6'($urandom_range(0, 63))},
             8'($urandom), $urandom_range(0, 3));
    end

    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 20'hFFFC0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("mid_fill_req", mem_req, 1'b1);
    @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_mem_addr", mem_addr, 20'h0);
    check("midrst_req_ready", req_ready, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    model_reset();
    @(negedge clk);
    check("midrst_hit_cnt", hit_cnt, 16'h0);
    check("midrst_miss_cnt", miss_cnt, 16'h0);
    rst_b = 1'b1;
    #1;
    check("midrst_ready_after", req_ready, 1'b1);
    @(negedge clk);
    do_req(1'b0, 20'h00078, 8'h00, 0);
    check("after_rst_miss", resp_hit, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
